mac_engine: RTL and testbench



---
 rtl/mac_engine.sv | 111 +++++++++++
 tb/tb_mac_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_engine.sv
// mac_engine: pops paired operands from two show-ahead FIFOs, accumulates an
// unsigned dot product of VEC_LEN element pairs and offers the sum on a
// valid/ready result port.
module mac_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned VEC_LEN    = 8,
    parameter int unsigned ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_empty,
    output logic                  a_rden,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  b_empty,
    output logic                  b_rden,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy
);

    localparam int unsigned CntWidth = $clog2(VEC_LEN) + 1;
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [CntWidth-1:0]     count_q, count_d;
    logic                    pop;
    logic [2*DATA_WIDTH-1:0] product;

    // Both FIFOs pop together or not at all; reset blocks any pop immediately.
    assign pop = (state_q == StRun) && !a_empty && !b_empty && !rst;

    assign product = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (pop && (count_q == LastCount)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: rden is combinational for the show-ahead pop, the rest
    // comes from registers only
    always_comb begin
        a_rden       = pop;
        b_rden       = pop;
        result       = acc_q;
        result_valid = (state_q == StDone);
        busy         = (state_q != StIdle);
    end

    // Accumulator / element counter next-state
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        if ((state_q == StIdle) && start) begin
            acc_d   = '0;
            count_d = '0;
        end else if (pop) begin
            // Product is zero-extended; the sum wraps at ACC_WIDTH
            acc_d   = acc_q + ACC_WIDTH'(product);
            count_d = count_q + CntWidth'(1);
        end
    end

    // Accumulator / counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mac_engine.sv
// Bench for mac_engine: table of operand vectors with hand-derived sums, a
// FIFO model feeding the DUT, and a scoreboard of expected results checked at
// each result handshake. A second instance with ACC_WIDTH=16 shares stimulus.
module tb_mac_engine;

    localparam int DW = 8;
    localparam int VL = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] a_data, b_data;
    logic          a_empty, b_empty;
    logic          a_rden, b_rden, w_a_rden, w_b_rden;
    logic [23:0]   result;
    logic [15:0]   w_result;
    logic          result_valid, w_result_valid;
    logic          result_ready;
    logic          busy, w_busy;

    mac_engine #(.DATA_WIDTH(DW), .VEC_LEN(VL), .ACC_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_data(a_data), .a_empty(a_empty), .a_rden(a_rden),
        .b_data(b_data), .b_empty(b_empty), .b_rden(b_rden),
        .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy)
    );

    mac_engine #(.DATA_WIDTH(DW), .VEC_LEN(VL), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start),
        .a_data(a_data), .a_empty(a_empty), .a_rden(w_a_rden),
        .b_data(b_data), .b_empty(b_empty), .b_rden(w_b_rden),
        .result(w_result), .result_valid(w_result_valid),
        .result_ready(result_ready), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a [VL];
        logic [DW-1:0] b [VL];
        logic [23:0]   exp24;
        logic [15:0]   exp16;
    } vec_t;

    typedef struct {
        logic [23:0] r24;
        logic [15:0] r16;
    } exp_t;

    vec_t          tbl [5];
    exp_t          exp_q [$];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];

    int  checks = 0;
    int  errors = 0;
    int  hs_seen = 0;
    int  runs = 0;
    int  vpops = 0;
    bit  in_run = 0;
    bit  a_stall = 0;
    bit  b_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        logic exp_pop;
        exp_t e;
        a_empty = (qa.size() == 0) || a_stall;
        b_empty = (qb.size() == 0) || b_stall;
        a_data  = (qa.size() != 0) ? qa[0] : '0;
        b_data  = (qb.size() != 0) ? qb[0] : '0;
        #1;
        exp_pop = in_run && !a_empty && !b_empty && !rst;
        check("a_rden", a_rden, exp_pop);
        check("b_rden", b_rden, exp_pop);
        check("w_a_rden", w_a_rden, exp_pop);
        if (exp_pop) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
            vpops++;
            if (vpops == VL) in_run = 0;
        end
        if (result_valid && result_ready && !rst) begin
            hs_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0d expected none", result);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.r24);
                check("result16", w_result, e.r16);
            end
        end
        @(negedge clk);
    endtask

    // Run one vector through the DUT; valid is expected first in cycle exp_cyc
    // counting the start cycle as 0.
    task automatic run_vec(input int idx, input int stall_at, input int stall_len,
                           input int ready_wait, input bit mid_start, input bit start_in_done,
                           input int exp_cyc);
        int n;
        int valid_n;
        int stall_used;
        int hs_before;
        exp_t e;
        for (int i = 0; i < VL; i++) begin
            qa.push_back(tbl[idx].a[i]);
            qb.push_back(tbl[idx].b[i]);
        end
        // Extra data in the FIFOs must stay untouched while the result waits
        if (ready_wait > 0) begin
            qa.push_back(8'd9);
            qb.push_back(8'd9);
        end
        e.r24 = tbl[idx].exp24;
        e.r16 = tbl[idx].exp16;
        exp_q.push_back(e);
        runs++;
        hs_before = hs_seen;
        vpops = 0;
        valid_n = 0;
        stall_used = 0;
        n = 0;
        result_ready = (ready_wait == 0);
        start = 1'b1;
        cycle();
        in_run = 1;
        start = 1'b0;
        while (hs_seen == hs_before && n < 60) begin
            n++;
            check("busy_active", busy, 1);
            check("valid_timing", result_valid, n >= exp_cyc);
            if (result_valid) begin
                check("result_held", result, tbl[idx].exp24);
                check("result16_held", w_result, tbl[idx].exp16);
                result_ready = (valid_n >= ready_wait);
                valid_n++;
            end else begin
                result_ready = (ready_wait == 0);
            end
            b_stall = (stall_len > 0) && (vpops == stall_at) && (stall_used < stall_len);
            if (b_stall) stall_used++;
            start = (mid_start && n == 3) || (start_in_done && result_valid);
            cycle();
        end
        start = 1'b0;
        b_stall = 0;
        result_ready = 1'b1;
        if (hs_seen == hs_before) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got none expected one for vector %0d", idx);
        end
        check("pops_per_vec", vpops, VL);
        check("valid_after_hs", result_valid, 0);
        check("busy_after_hs", busy, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("idle_busy", busy, 0);
        end
        qa.delete();
        qb.delete();
    endtask

    initial begin
        // Vector table with hand-computed sums
        for (int i = 0; i < VL; i++) begin
            tbl[0].a[i] = DW'(i + 1);  tbl[0].b[i] = 8'd2;
            tbl[1].a[i] = 8'd3;        tbl[1].b[i] = 8'd4;
            tbl[2].a[i] = 8'd255;      tbl[2].b[i] = 8'd255;
            tbl[3].a[i] = 8'd0;        tbl[3].b[i] = DW'(7 * i + 5);
            tbl[4].a[i] = DW'(i + 1);  tbl[4].b[i] = DW'(VL - i);
        end
        tbl[0].exp24 = 24'd72;     tbl[0].exp16 = 16'd72;
        tbl[1].exp24 = 24'd96;     tbl[1].exp16 = 16'd96;
        tbl[2].exp24 = 24'd520200; tbl[2].exp16 = 16'd61448;
        tbl[3].exp24 = 24'd0;      tbl[3].exp16 = 16'd0;
        tbl[4].exp24 = 24'd120;    tbl[4].exp16 = 16'd120;

        rst = 1'b1;
        start = 1'b0;
        result_ready = 1'b1;
        a_data = '0;
        b_data = '0;
        a_empty = 1'b1;
        b_empty = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Idle with start low and data present: nothing happens
        qa.push_back(8'd1);
        qb.push_back(8'd1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("idle_hold_busy", busy, 0);
        end
        qa.delete();
        qb.delete();

        for (int v = 0; v < 5; v++) run_vec(v, 0, 0, 0, 0, 0, VL + 1);

        // B empty for 3 cycles after the 4th pop
        run_vec(0, 4, 3, 0, 0, 0, VL + 4);
        // Backpressure for 5 cycles with start pulses ignored in DONE
        run_vec(4, 0, 0, 5, 0, 1, VL + 1);
        // Start pulse while running does not restart
        run_vec(1, 0, 0, 0, 1, 0, VL + 1);

        // Reset after 3 pops: partial sum discarded, no result produced
        for (int i = 0; i < VL; i++) begin
            qa.push_back(tbl[0].a[i]);
            qb.push_back(tbl[0].b[i]);
        end
        vpops = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        in_run = 1;
        for (int k = 0; k < 3; k++) cycle();
        check("pops_before_rst", vpops, 3);
        rst = 1'b1;
        in_run = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("midrst_result", result, 0);
            check("midrst_result16", w_result, 0);
            check("midrst_valid", result_valid, 0);
            check("midrst_busy", busy, 0);
        end
        rst = 1'b0;
        qa.delete();
        qb.delete();
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("postrst_busy", busy, 0);
        end
        run_vec(1, 0, 0, 0, 0, 0, VL + 1);

        check("scoreboard_empty", exp_q.size(), 0);
        check("result_count", hs_seen, runs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
